// File: rtl/dsp_simd_pkg.sv
// Shared definitions for the 4-lane 12-bit SIMD adder datapath (packer and unpacker).
package dsp_simd_pkg;

    localparam int LANE_W = 12;
    localparam int LANES  = 4;
    localparam int PACK_W = 2 * LANE_W * LANES;
    localparam int RES_W  = LANE_W * LANES;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE
    } packer_state_t;

    // Operand a of lane k sits at the bottom of that lane's 24-bit slot.
    function automatic int a_lsb(input int k);
        return 2 * LANE_W * k;
    endfunction

    // Operand b of lane k sits directly above its operand a.
    function automatic int b_lsb(input int k);
        return 2 * LANE_W * k + LANE_W;
    endfunction

    // DSP results come back with lane 0 in the most significant slot.
    function automatic int res_lsb(input int k);
        return RES_W - LANE_W - LANE_W * k;
    endfunction

endpackage

// File: rtl/dsp_add_4simd_packer_if.sv
// Request stream and bundle stream between HLS datapaths, the packer and the DSP stage.
interface dsp_add_4simd_packer_if #(
    parameter int TAG_W = 4
);
    import dsp_simd_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [LANE_W-1:0]        in_a;
    logic [LANE_W-1:0]        in_b;
    logic [TAG_W-1:0]         in_tag;

    logic                     out_valid;
    logic                     out_ready;
    logic [PACK_W-1:0]        out_inputs;
    logic [LANES-1:0]         out_mask;
    logic [LANES*TAG_W-1:0]   out_tags;

    // Packer side: consumes requests, produces bundles.
    modport master (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_inputs, out_mask, out_tags
    );

    // Environment side: produces requests, consumes bundles.
    modport slave (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_inputs, out_mask, out_tags
    );

endinterface

// File: rtl/dsp_add_4simd_packer.sv
// Gathers up to four scalar add requests into one SIMD operand word for the
// 4x12-bit adder DSP stage, issuing when full, on timeout or on flush.
module dsp_add_4simd_packer
    import dsp_simd_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   flush,
    dsp_add_4simd_packer_if.master bus
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = $clog2(LANES);

    packer_state_t          r_state;
    packer_state_t          w_nextState;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_nextCnt;
    logic [CNT_W-1:0]       w_cntPost;
    logic [TMR_W-1:0]       r_timer;
    logic [TMR_W-1:0]       w_nextTimer;

    logic                   w_inReady;
    logic                   w_accept;
    logic                   w_handshake;
    logic                   w_timeoutHit;
    logic                   w_clear;
    logic [IDX_W-1:0]       w_writeIdx;
    logic [LANES-1:0]       w_laneWe;

    logic [LANE_W-1:0]      r_laneA   [LANES];
    logic [LANE_W-1:0]      r_laneB   [LANES];
    logic [TAG_W-1:0]       r_laneTag [LANES];
    logic [LANES-1:0]       r_mask;

    logic [PACK_W-1:0]      w_inputs;
    logic [LANES*TAG_W-1:0] w_tags;

    // While a bundle waits for the DSP, a new request only fits if the bundle leaves this cycle.
    assign w_inReady   = ce & rst_n & ((r_state != ISSUE) | bus.out_ready);
    assign w_accept    = bus.in_valid & w_inReady;
    assign w_handshake = ce & (r_state == ISSUE) & bus.out_ready;

    // The timer counts from the first accept and is never restarted by later ones.
    generate
        if (TIMEOUT == 0) begin : g_noTimeout
            assign w_timeoutHit = 1'b0;
        end else begin : g_timeout
            assign w_timeoutHit = (r_timer == TMR_W'(TIMEOUT - 1));
        end
    endgenerate

    // Next-state, lane-select and bundle-clear decisions.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextTimer = r_timer;
        w_cntPost   = r_cnt;
        w_writeIdx  = '0;
        w_clear     = 1'b0;
        w_laneWe    = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextCnt   = CNT_W'(1);
                    w_nextTimer = TMR_W'(1);
                    w_nextState = FILL;
                end
            end
            FILL: begin
                w_nextTimer = r_timer + TMR_W'(1);
                w_writeIdx  = r_cnt[IDX_W-1:0];
                if (w_accept) begin
                    w_cntPost = r_cnt + CNT_W'(1);
                end
                w_nextCnt = w_cntPost;
                if ((w_cntPost == CNT_W'(LANES)) || flush || w_timeoutHit) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (w_handshake) begin
                    w_clear = 1'b1;
                    if (w_accept) begin
                        w_nextCnt   = CNT_W'(1);
                        w_nextTimer = TMR_W'(1);
                        w_nextState = FILL;
                    end else begin
                        w_nextCnt   = '0;
                        w_nextTimer = '0;
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
                w_nextTimer = '0;
            end
        endcase

        w_laneWe[w_writeIdx] = w_accept;
    end

    // Control state advances only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
        end else if (ce) begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_timer <= w_nextTimer;
        end
    end

    // Lane registers: a decoded write loads one lane, a handshake zeroes every lane not being refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                r_laneA[k]   <= '0;
                r_laneB[k]   <= '0;
                r_laneTag[k] <= '0;
            end
            r_mask <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (w_laneWe[k]) begin
                    r_laneA[k]   <= bus.in_a;
                    r_laneB[k]   <= bus.in_b;
                    r_laneTag[k] <= bus.in_tag;
                    r_mask[k]    <= 1'b1;
                end else if (w_clear) begin
                    r_laneA[k]   <= '0;
                    r_laneB[k]   <= '0;
                    r_laneTag[k] <= '0;
                    r_mask[k]    <= 1'b0;
                end
            end
        end
    end

    // Lay the lanes out in the DSP four12 operand format.
    always_comb begin
        w_inputs = '0;
        w_tags   = '0;
        for (int k = 0; k < LANES; k++) begin
            w_inputs[a_lsb(k) +: LANE_W] = r_laneA[k];
            w_inputs[b_lsb(k) +: LANE_W] = r_laneB[k];
            w_tags[TAG_W*k +: TAG_W]     = r_laneTag[k];
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = (r_state == ISSUE);
    assign bus.out_inputs = w_inputs;
    assign bus.out_mask   = r_mask;
    assign bus.out_tags   = w_tags;

endmodule

// File: tb/tb_dsp_add_4simd_packer.sv
// Bench for the SIMD operand packer: directed scenarios plus a randomized run
// against a queue-based model of bundle formation.
module tb_dsp_add_4simd_packer;
    import dsp_simd_pkg::*;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;
    logic flush = 1'b0;

    int nChecks = 0;
    int nPass   = 0;

    // Model: requests gathered so far, the bundle on offer, and cycles since the first gather.
    req_t mCur[$];
    req_t mOut[$];
    bit   mIssued = 1'b0;
    int   mAge    = 0;

    dsp_add_4simd_packer_if #(.TAG_W(TAG_W)) bus ();

    dsp_add_4simd_packer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelReady();
        return ce && rst_n && (!mIssued || bus.out_ready);
    endfunction

    function automatic logic [PACK_W-1:0] expInputs();
        logic [PACK_W-1:0] v;
        v = '0;
        for (int k = 0; k < mOut.size(); k++) begin
            v[24*k +: 12]      = mOut[k].a;
            v[24*k + 12 +: 12] = mOut[k].b;
        end
        return v;
    endfunction

    function automatic logic [LANES-1:0] expMask();
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < mOut.size(); k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [LANES*TAG_W-1:0] expTags();
        logic [LANES*TAG_W-1:0] t;
        t = '0;
        for (int k = 0; k < mOut.size(); k++) t[TAG_W*k +: TAG_W] = mOut[k].tag;
        return t;
    endfunction

    task automatic modelReset();
        mCur.delete();
        mOut.delete();
        mIssued = 1'b0;
        mAge    = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic [LANE_W-1:0] a,
                                 input logic [LANE_W-1:0] b, input logic [TAG_W-1:0] tag);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    // One clock: sample inputs mid-cycle, advance the model on the edge, return 1 time unit later.
    task automatic tick();
        logic acc, consume, collecting, hit, fl, doStep;
        req_t r;
        @(negedge clk);
        doStep     = ce && rst_n;
        acc        = bus.in_valid && modelReady();
        consume    = mIssued && bus.out_ready && ce;
        collecting = !mIssued && (mCur.size() > 0);
        hit        = (TIMEOUT != 0) && (mAge == TIMEOUT - 1);
        fl         = flush;
        r.a        = bus.in_a;
        r.b        = bus.in_b;
        r.tag      = bus.in_tag;
        @(posedge clk);
        if (doStep) begin
            if (consume) begin
                mIssued = 1'b0;
                mOut.delete();
            end
            if (collecting) mAge++;
            if (acc) begin
                if (mCur.size() == 0) mAge = 1;
                mCur.push_back(r);
            end
            if (collecting && ((mCur.size() == LANES) || fl || hit)) begin
                mOut = mCur;
                mCur.delete();
                mIssued = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); else nPass++;
        nChecks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", bus.in_ready); else nPass++;
        nChecks++; if (bus.out_mask !== 4'h0) $display("[TB] FAIL reset_mask: got %h expected 0", bus.out_mask); else nPass++;
        nChecks++; if (bus.out_inputs !== '0) $display("[TB] FAIL reset_inputs: got %h expected 0", bus.out_inputs); else nPass++;
        nChecks++; if (bus.out_tags !== '0) $display("[TB] FAIL reset_tags: got %h expected 0", bus.out_tags); else nPass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ce    = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        nChecks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL idle_ready: got %b expected 1", bus.in_ready); else nPass++;
    endtask

    task automatic test_full_bundle();
        logic [PACK_W-1:0] expV;
        logic [LANE_W-1:0] av, bv;
        expV = '0;
        for (int k = 0; k < 4; k++) begin
            av = 12'(k + 1);
            bv = 12'(10 * (k + 1));
            expV[24*k +: 12]      = av;
            expV[24*k + 12 +: 12] = bv;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 12'(i + 1), 12'(10 * (i + 1)), 4'(i));
            #1;
            nChecks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL full_ready: lane %0d got %b expected 1", i, bus.in_ready); else nPass++;
            tick();
            if (i < 3) begin
                nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL full_early_valid: after accept %0d got %b expected 0", i, bus.out_valid); else nPass++;
            end
        end
        applyStimulus(1'b0, '0, '0, '0);
        nChecks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL full_valid: got %b expected 1", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_mask !== 4'hF) $display("[TB] FAIL full_mask: got %h expected f", bus.out_mask); else nPass++;
        nChecks++; if (bus.out_tags !== 16'h3210) $display("[TB] FAIL full_tags: got %h expected 3210", bus.out_tags); else nPass++;
        nChecks++; if (bus.out_inputs !== expV) $display("[TB] FAIL full_inputs: got %h expected %h", bus.out_inputs, expV); else nPass++;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL full_consumed: got %b expected 0", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_mask !== 4'h0) $display("[TB] FAIL full_cleared_mask: got %h expected 0", bus.out_mask); else nPass++;
    endtask

    task automatic test_timeout();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 12'h7FF, 12'h800, 4'hA);
        tick();
        applyStimulus(1'b1, 12'h001, 12'hFFF, 4'h5);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        for (int n = 3; n <= 8; n++) begin
            tick();
            nChecks++;
            if (bus.out_valid !== (n == 8)) $display("[TB] FAIL timeout_valid: cycle %0d got %b expected %b", n, bus.out_valid, (n == 8));
            else nPass++;
        end
        nChecks++; if (bus.out_mask !== 4'h3) $display("[TB] FAIL timeout_mask: got %h expected 3", bus.out_mask); else nPass++;
        nChecks++; if (bus.out_inputs[95:48] !== 48'h0) $display("[TB] FAIL timeout_upper_zero: got %h expected 0", bus.out_inputs[95:48]); else nPass++;
        nChecks++; if (bus.out_inputs[47:0] !== 48'hFFF_001_800_7FF) $display("[TB] FAIL timeout_lower: got %h expected fff0018007ff", bus.out_inputs[47:0]); else nPass++;
        nChecks++; if (bus.out_tags !== 16'h005A) $display("[TB] FAIL timeout_tags: got %h expected 005a", bus.out_tags); else nPass++;
        tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'(100 + i), 12'(200 + i), 4'(i + 4));
            tick();
        end
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_early_valid: got %b expected 0", bus.out_valid); else nPass++;
        applyStimulus(1'b1, 12'd103, 12'd203, 4'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        nChecks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL flush_full_valid: got %b expected 1", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_mask !== 4'hF) $display("[TB] FAIL flush_full_mask: got %h expected f", bus.out_mask); else nPass++;
        nChecks++; if (bus.out_tags !== 16'h7654) $display("[TB] FAIL flush_full_tags: got %h expected 7654", bus.out_tags); else nPass++;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_single_bundle: got %b expected 0", bus.out_valid); else nPass++;
        flush = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_idle: cycle %0d got %b expected 0", c, bus.out_valid); else nPass++;
        end
        flush = 1'b0;
        applyStimulus(1'b1, 12'h0AB, 12'h0CD, 4'h1);
        tick();
        applyStimulus(1'b1, 12'h0EF, 12'h012, 4'h2);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL flush_partial_valid: got %b expected 1", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_mask !== 4'h3) $display("[TB] FAIL flush_partial_mask: got %h expected 3", bus.out_mask); else nPass++;
        tick();
    endtask

    task automatic test_backpressure();
        req_t reqs[4];
        req_t nxt;
        logic [PACK_W-1:0]      expV;
        logic [LANES*TAG_W-1:0] expT;
        expV = '0;
        expT = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reqs[i].a   = 12'($urandom);
            reqs[i].b   = 12'($urandom);
            reqs[i].tag = 4'($urandom);
            expV[24*i +: 12]      = reqs[i].a;
            expV[24*i + 12 +: 12] = reqs[i].b;
            expT[4*i +: 4]        = reqs[i].tag;
            applyStimulus(1'b1, reqs[i].a, reqs[i].b, reqs[i].tag);
            tick();
        end
        nxt.a   = 12'($urandom);
        nxt.b   = 12'($urandom);
        nxt.tag = 4'($urandom);
        applyStimulus(1'b1, nxt.a, nxt.b, nxt.tag);
        for (int c = 0; c < 5; c++) begin
            #1;
            nChecks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_ready: cycle %0d got %b expected 0", c, bus.in_ready); else nPass++;
            tick();
            nChecks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_valid: cycle %0d got %b expected 1", c, bus.out_valid); else nPass++;
            nChecks++; if (bus.out_inputs !== expV) $display("[TB] FAIL bp_inputs: cycle %0d got %h expected %h", c, bus.out_inputs, expV); else nPass++;
            nChecks++; if (bus.out_tags !== expT) $display("[TB] FAIL bp_tags: cycle %0d got %h expected %h", c, bus.out_tags, expT); else nPass++;
        end
        bus.out_ready = 1'b1;
        #1;
        nChecks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.in_ready); else nPass++;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b expected 0", bus.out_valid); else nPass++;
        applyStimulus(1'b0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (bus.out_mask !== 4'h1) $display("[TB] FAIL bp_next_mask: got %h expected 1", bus.out_mask); else nPass++;
        nChecks++;
        if (bus.out_inputs !== {72'h0, nxt.b, nxt.a}) $display("[TB] FAIL bp_next_lane0: got %h expected %h", bus.out_inputs, {72'h0, nxt.b, nxt.a});
        else nPass++;
        nChecks++; if (bus.out_tags !== {12'h0, nxt.tag}) $display("[TB] FAIL bp_next_tag: got %h expected %h", bus.out_tags, {12'h0, nxt.tag}); else nPass++;
        tick();
    endtask

    task automatic test_ce();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 12'h111, 12'h222, 4'h3);
        tick();
        applyStimulus(1'b1, 12'h333, 12'h444, 4'hC);
        tick();
        applyStimulus(1'b1, 12'h555, 12'h666, 4'h9);
        flush = 1'b1;
        ce    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            nChecks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL ce_fill_ready: cycle %0d got %b expected 0", c, bus.in_ready); else nPass++;
            tick();
            nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL ce_fill_valid: cycle %0d got %b expected 0", c, bus.out_valid); else nPass++;
        end
        ce    = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        for (int n = 1; n <= 6; n++) begin
            tick();
            nChecks++;
            if (bus.out_valid !== (n == 6)) $display("[TB] FAIL ce_timer_frozen: cycle %0d got %b expected %b", n, bus.out_valid, (n == 6));
            else nPass++;
        end
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            nChecks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL ce_issue_ready: cycle %0d got %b expected 0", c, bus.in_ready); else nPass++;
            tick();
            nChecks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL ce_issue_valid: cycle %0d got %b expected 1", c, bus.out_valid); else nPass++;
            nChecks++;
            if (bus.out_inputs !== {48'h0, 12'h444, 12'h333, 12'h222, 12'h111}) $display("[TB] FAIL ce_issue_inputs: cycle %0d got %h expected 444333222111", c, bus.out_inputs);
            else nPass++;
            nChecks++; if (bus.out_mask !== 4'h3) $display("[TB] FAIL ce_issue_mask: cycle %0d got %h expected 3", c, bus.out_mask); else nPass++;
        end
        ce = 1'b1;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL ce_resume_consume: got %b expected 0", bus.out_valid); else nPass++;
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 12'hABC, 12'hDEF, 4'h6);
        tick();
        applyStimulus(1'b1, 12'h135, 12'h246, 4'h7);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL arst_fill_valid: got %b expected 0", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_mask !== 4'h0) $display("[TB] FAIL arst_fill_mask: got %h expected 0", bus.out_mask); else nPass++;
        nChecks++; if (bus.out_inputs !== '0) $display("[TB] FAIL arst_fill_inputs: got %h expected 0", bus.out_inputs); else nPass++;
        nChecks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL arst_fill_ready: got %b expected 0", bus.in_ready); else nPass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 12'h321, 12'h654, 4'h9);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (bus.out_mask !== 4'h1) $display("[TB] FAIL arst_relaunch_mask: got %h expected 1", bus.out_mask); else nPass++;
        nChecks++;
        if (bus.out_inputs !== {72'h0, 12'h654, 12'h321}) $display("[TB] FAIL arst_relaunch_lane0: got %h expected 654321", bus.out_inputs);
        else nPass++;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL arst_issue_valid: got %b expected 0", bus.out_valid); else nPass++;
        nChecks++; if (bus.out_tags !== '0) $display("[TB] FAIL arst_issue_tags: got %h expected 0", bus.out_tags); else nPass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 12'h0F0, 12'h00F, 4'hE);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++;
        if (bus.out_inputs !== {72'h0, 12'h00F, 12'h0F0}) $display("[TB] FAIL arst_issue_relaunch: got %h expected 00f0f0", bus.out_inputs);
        else nPass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ce            = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 2) != 0, 12'($urandom), 12'($urandom), 4'($urandom));
            #1;
            nChecks++; if (bus.in_ready !== modelReady()) $display("[TB] FAIL rand_ready: cycle %0d got %b expected %b", c, bus.in_ready, modelReady()); else nPass++;
            tick();
            nChecks++; if (bus.out_valid !== mIssued) $display("[TB] FAIL rand_valid: cycle %0d got %b expected %b", c, bus.out_valid, mIssued); else nPass++;
            if (mIssued) begin
                nChecks++; if (bus.out_mask !== expMask()) $display("[TB] FAIL rand_mask: cycle %0d got %h expected %h", c, bus.out_mask, expMask()); else nPass++;
                nChecks++; if (bus.out_inputs !== expInputs()) $display("[TB] FAIL rand_inputs: cycle %0d got %h expected %h", c, bus.out_inputs, expInputs()); else nPass++;
                nChecks++; if (bus.out_tags !== expTags()) $display("[TB] FAIL rand_tags: cycle %0d got %h expected %h", c, bus.out_tags, expTags()); else nPass++;
            end
        end
        ce            = 1'b1;
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, '0);
        tick();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rand_drain: got %b expected 0", bus.out_valid); else nPass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_bundle();
        test_timeout();
        test_flush();
        test_backpressure();
        test_ce();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
